// File: rtl/axis_pkg.sv
// Shared types and width helpers for the AXI-Stream TX FIFO.
// Holds the default-configuration word layout and the pointer/level width rules.
package axis_pkg;

    localparam int AXIS_DATA_WIDTH = 32;
    localparam int AXIS_DEPTH      = 16;

    localparam int ADDR_W  = $clog2(AXIS_DEPTH);
    localparam int LEVEL_W = ADDR_W + 1;

    typedef struct packed {
        logic [AXIS_DATA_WIDTH-1:0] data;
        logic                       last;
    } axis_word_t;

    function automatic int addr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    // One extra bit so full and empty are told apart by the pointer MSB.
    function automatic int level_w(input int depth);
        return addr_w(depth) + 1;
    endfunction

endpackage

// File: rtl/axis_fifo_ram.sv
// Storage array for the TX FIFO: one synchronous write port, one asynchronous read port.
// The asynchronous read lets the top reload its output register in the same cycle as a pop.
module axis_fifo_ram
    import axis_pkg::*;
#(
    parameter int WIDTH = $bits(axis_word_t),
    parameter int DEPTH = AXIS_DEPTH,
    parameter int AW    = addr_w(DEPTH)
) (
    input  logic             clk,
    input  logic             i_we,
    input  logic [AW-1:0]    i_waddr,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic [AW-1:0]    i_raddr,
    output logic [WIDTH-1:0] o_rdata
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/axis_tx_fifo.sv
// Elastic AXI-Stream buffer from the host source to the MAC TX path, first-word-fall-through output.
// Define AXIS_TX_FIFO_FRAME_MODE_EN for store-and-forward egress; otherwise it runs cut-through.
module axis_tx_fifo
    import axis_pkg::*;
#(
    parameter int DATA_WIDTH = AXIS_DATA_WIDTH,
    parameter int DEPTH      = AXIS_DEPTH
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [DATA_WIDTH-1:0]   s_axis_tdata,
    input  logic                    s_axis_tvalid,
    input  logic                    s_axis_tlast,
    output logic                    s_axis_trdy,
    output logic [DATA_WIDTH-1:0]   m_axis_tdata,
    output logic                    m_axis_tvalid,
    output logic                    m_axis_tlast,
    input  logic                    m_axis_trdy,
    output logic [$clog2(DEPTH):0]  fifo_level
);

    localparam int AW = addr_w(DEPTH);
    localparam int LW = level_w(DEPTH);
    localparam logic [LW-1:0] ONE_WORD = LW'(1);

    typedef struct packed {
        logic [DATA_WIDTH-1:0] data;
        logic                  last;
    } word_t;

    logic [LW-1:0] r_wr_ptr;
    logic [LW-1:0] r_rd_ptr;
    logic [LW-1:0] w_wr_ptr_next;
    logic [LW-1:0] w_rd_ptr_next;
    logic [LW-1:0] w_level;
    logic [LW-1:0] w_level_next;
    logic          r_s_trdy;
    logic          r_m_tvalid;
    logic          w_m_tvalid_next;
    word_t         r_out;
    word_t         w_out_next;
    word_t         w_ram_rdata;
    word_t         w_wr_word;
    logic          w_wr_en;
    logic          w_rd_en;
    logic          w_empty;
    logic          w_full_next;
    logic [AW-1:0] w_ram_raddr;

    assign w_wr_en   = s_axis_tvalid & r_s_trdy;
    assign w_rd_en   = r_m_tvalid & m_axis_trdy;
    assign w_wr_word = {s_axis_tdata, s_axis_tlast};

    assign w_wr_ptr_next = r_wr_ptr + LW'(w_wr_en);
    assign w_rd_ptr_next = r_rd_ptr + LW'(w_rd_en);
    assign w_level       = r_wr_ptr - r_rd_ptr;
    assign w_level_next  = w_wr_ptr_next - w_rd_ptr_next;
    assign w_empty       = (r_wr_ptr == r_rd_ptr);
    assign w_full_next   = (w_wr_ptr_next[AW] != w_rd_ptr_next[AW]) &&
                           (w_wr_ptr_next[AW-1:0] == w_rd_ptr_next[AW-1:0]);

    // The head word stays in the array until popped; the output register mirrors it,
    // so the word behind the head is what gets loaded on a pop.
    assign w_ram_raddr = r_rd_ptr[AW-1:0] + AW'(1);

    axis_fifo_ram #(
        .WIDTH (DATA_WIDTH + 1),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk     (clk),
        .i_we    (w_wr_en),
        .i_waddr (r_wr_ptr[AW-1:0]),
        .i_wdata (w_wr_word),
        .i_raddr (w_ram_raddr),
        .o_rdata (w_ram_rdata)
    );

    always_comb begin
        w_out_next = r_out;
        if (w_rd_en) begin
            if (w_level > ONE_WORD) begin
                w_out_next = w_ram_rdata;
            end else if (w_wr_en) begin
                w_out_next = w_wr_word;
            end
        end else if (w_empty && w_wr_en) begin
            w_out_next = w_wr_word;
        end
    end

`ifdef AXIS_TX_FIFO_FRAME_MODE_EN
    logic [LW-1:0] r_frame_cnt;
    logic [LW-1:0] w_frame_cnt_next;
    logic          r_egress;
    logic          w_egress_next;
    logic          w_frame_in;
    logic          w_frame_out;

    assign w_frame_in  = w_wr_en & s_axis_tlast;
    assign w_frame_out = w_rd_en & r_out.last;

    always_comb begin
        w_frame_cnt_next = r_frame_cnt;
        if (w_frame_in && !w_frame_out) begin
            w_frame_cnt_next = r_frame_cnt + ONE_WORD;
        end else if (w_frame_out && !w_frame_in) begin
            w_frame_cnt_next = r_frame_cnt - ONE_WORD;
        end
    end

    // A frame that has started leaving keeps streaming, including an oversize one released by full.
    always_comb begin
        w_egress_next = r_egress;
        if (w_rd_en) begin
            w_egress_next = !r_out.last;
        end
    end

    assign w_m_tvalid_next = (w_level_next != '0) &&
                             ((w_frame_cnt_next != '0) || w_full_next || w_egress_next);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_frame_cnt <= '0;
            r_egress    <= 1'b0;
        end else begin
            r_frame_cnt <= w_frame_cnt_next;
            r_egress    <= w_egress_next;
        end
    end
`else
    assign w_m_tvalid_next = (w_level_next != '0);
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_s_trdy   <= 1'b0;
            r_m_tvalid <= 1'b0;
            r_out      <= '0;
        end else begin
            r_wr_ptr   <= w_wr_ptr_next;
            r_rd_ptr   <= w_rd_ptr_next;
            r_s_trdy   <= !w_full_next;
            r_m_tvalid <= w_m_tvalid_next;
            r_out      <= w_out_next;
        end
    end

    assign s_axis_trdy   = r_s_trdy;
    assign m_axis_tvalid = r_m_tvalid;
    assign m_axis_tdata  = r_out.data;
    assign m_axis_tlast  = r_out.last;
    assign fifo_level    = w_level;

endmodule

// File: tb/tb_axis_tx_fifo.sv
// Directed self-checking bench for axis_tx_fifo (DATA_WIDTH=32, DEPTH=16).
// Frame-mode checks are compiled in when AXIS_TX_FIFO_FRAME_MODE_EN is defined.
module tb_axis_tx_fifo;

`ifdef AXIS_TX_FIFO_FRAME_MODE_EN
    localparam bit FRAME_MODE = 1'b1;
`else
    localparam bit FRAME_MODE = 1'b0;
`endif

    logic        clk;
    logic        reset;
    logic [31:0] s_axis_tdata;
    logic        s_axis_tvalid;
    logic        s_axis_tlast;
    logic        s_axis_trdy;
    logic [31:0] m_axis_tdata;
    logic        m_axis_tvalid;
    logic        m_axis_tlast;
    logic        m_axis_trdy;
    logic [4:0]  fifo_level;

    int n_checks = 0;
    int n_errors = 0;

    axis_tx_fifo #(
        .DATA_WIDTH (32),
        .DEPTH      (16)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tlast  (s_axis_tlast),
        .s_axis_trdy   (s_axis_trdy),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tlast  (m_axis_tlast),
        .m_axis_trdy   (m_axis_trdy),
        .fifo_level    (fifo_level)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic is_last(input int i, input int flen, input int n);
        return ((i % flen) == (flen - 1)) || (i == n - 1);
    endfunction

    // Drives both sides from negedge to negedge and scoreboards words base+rd0 .. base+n-1.
    task automatic stream(input logic [31:0] base, input int wr0, input int rd0, input int n,
                          input int flen, input int vpct, input int rpct, input int budget,
                          output int cycles);
        int          wr;
        int          rd;
        int          cyc;
        logic        prev_stall;
        logic [31:0] prev_data;
        logic        prev_last;
        wr = wr0;
        rd = rd0;
        cyc = 0;
        prev_stall = 1'b0;
        prev_data = '0;
        prev_last = 1'b0;
        while ((rd < n) && (cyc < budget)) begin
            s_axis_tvalid = (wr < n) && ($urandom_range(99) < vpct);
            s_axis_tdata  = base + wr;
            s_axis_tlast  = is_last(wr, flen, n);
            m_axis_trdy   = ($urandom_range(99) < rpct);
            if (prev_stall) begin
                chk("hold_valid", m_axis_tvalid, 1);
                chk("hold_data", m_axis_tdata, prev_data);
                chk("hold_last", m_axis_tlast, prev_last);
            end
            if (s_axis_tvalid && s_axis_trdy) wr++;
            if (m_axis_tvalid && m_axis_trdy) begin
                chk("out_data", m_axis_tdata, base + rd);
                chk("out_last", m_axis_tlast, is_last(rd, flen, n));
                $display("  word %0d data=0x%08h last=%0b", rd, m_axis_tdata, m_axis_tlast);
                rd++;
            end
            prev_stall = m_axis_tvalid && !m_axis_trdy;
            prev_data  = m_axis_tdata;
            prev_last  = m_axis_tlast;
            @(negedge clk);
            cyc++;
        end
        s_axis_tvalid = 1'b0;
        s_axis_tlast  = 1'b0;
        m_axis_trdy   = 1'b0;
        chk("stream_words_out", rd, n);
        chk("stream_no_extra", m_axis_tvalid, 0);
        chk("stream_level_end", fifo_level, 0);
        cycles = cyc;
    endtask

    initial begin
        int   wr;
        int   cyc;
        logic acc;

        reset = 1'b1;
        s_axis_tdata = '0;
        s_axis_tvalid = 1'b0;
        s_axis_tlast = 1'b0;
        m_axis_trdy = 1'b0;

        // Reset values
        @(negedge clk);
        @(negedge clk);
        chk("rst_trdy", s_axis_trdy, 0);
        chk("rst_tvalid", m_axis_tvalid, 0);
        chk("rst_tdata", m_axis_tdata, 0);
        chk("rst_tlast", m_axis_tlast, 0);
        chk("rst_level", fifo_level, 0);
        reset = 1'b0;
        @(negedge clk);
        chk("trdy_after_release", s_axis_trdy, 1);

        // 1: single word, one-cycle latency
        s_axis_tvalid = 1'b1;
        s_axis_tdata = 32'hDEADBEEF;
        s_axis_tlast = 1'b1;
        m_axis_trdy = 1'b1;
        chk("t1_valid_before", m_axis_tvalid, 0);
        @(negedge clk);
        s_axis_tvalid = 1'b0;
        s_axis_tlast = 1'b0;
        chk("t1_valid", m_axis_tvalid, 1);
        chk("t1_data", m_axis_tdata, 32'hDEADBEEF);
        chk("t1_last", m_axis_tlast, 1);
        chk("t1_level1", fifo_level, 1);
        $display("t1 word data=0x%08h last=%0b", m_axis_tdata, m_axis_tlast);
        @(negedge clk);
        chk("t1_valid_after", m_axis_tvalid, 0);
        chk("t1_level0", fifo_level, 0);
        m_axis_trdy = 1'b0;

        // 2: fill to full with the reader stalled, then drain 20 words in order
        wr = 0;
        for (int c = 0; c < 24; c++) begin
            s_axis_tvalid = (wr < 20);
            s_axis_tdata = wr;
            s_axis_tlast = (wr == 19);
            acc = s_axis_tvalid && s_axis_trdy;
            @(negedge clk);
            if (acc) wr++;
            chk("t2_fill_valid", m_axis_tvalid, FRAME_MODE ? (wr >= 16) : (wr >= 1));
        end
        chk("t2_accepted", wr, 16);
        chk("t2_trdy_full", s_axis_trdy, 0);
        chk("t2_level_full", fifo_level, 16);
        chk("t2_head", m_axis_tdata, 0);
        $display("t2 full level=%0d trdy=%0b", fifo_level, s_axis_trdy);
        m_axis_trdy = 1'b1;
        @(negedge clk);
        chk("t2_trdy_rise", s_axis_trdy, 1);
        chk("t2_level_15", fifo_level, 15);
        stream(32'h0, 16, 1, 20, 20, 100, 100, 100, cyc);

        // 3: 64-word frame at full rate
        stream(32'h3000, 0, 0, 64, 64, 100, 100, 300, cyc);
        $display("t3 cycles=%0d", cyc);
`ifndef AXIS_TX_FIFO_FRAME_MODE_EN
        chk("t3_throughput", cyc, 65);
`endif

        // 4: random valid/ready, 1000 words in 8-word frames
        stream(32'h40000, 0, 0, 1000, 8, 70, 60, 20000, cyc);
        $display("t4 cycles=%0d", cyc);

        // 5: reset in the middle of an 8-word frame
        m_axis_trdy = 1'b0;
        for (int k = 0; k < 5; k++) begin
            s_axis_tvalid = 1'b1;
            s_axis_tdata = 32'h500 + k;
            s_axis_tlast = 1'b0;
            @(negedge clk);
        end
        s_axis_tvalid = 1'b0;
        chk("t5_level5", fifo_level, 5);
        chk("t5_head", m_axis_tdata, 32'h500);
        chk("t5_valid", m_axis_tvalid, FRAME_MODE ? 0 : 1);
        #2;
        reset = 1'b1;
        #1;
        chk("t5_rst_trdy", s_axis_trdy, 0);
        chk("t5_rst_tvalid", m_axis_tvalid, 0);
        chk("t5_rst_tdata", m_axis_tdata, 0);
        chk("t5_rst_level", fifo_level, 0);
        $display("t5 reset asserted level=%0d", fifo_level);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("t5_trdy_back", s_axis_trdy, 1);
        stream(32'h5100, 0, 0, 3, 3, 100, 100, 50, cyc);

`ifdef AXIS_TX_FIFO_FRAME_MODE_EN
        // 6a: store-and-forward holds a frame until its last word is in
        m_axis_trdy = 1'b1;
        for (int k = 0; k < 4; k++) begin
            s_axis_tvalid = 1'b1;
            s_axis_tdata = 32'h600 + k;
            s_axis_tlast = (k == 3);
            chk("t6_hold", m_axis_tvalid, 0);
            @(negedge clk);
        end
        s_axis_tvalid = 1'b0;
        s_axis_tlast = 1'b0;
        for (int k = 0; k < 4; k++) begin
            chk("t6_valid", m_axis_tvalid, 1);
            chk("t6_data", m_axis_tdata, 32'h600 + k);
            $display("t6 word %0d data=0x%08h", k, m_axis_tdata);
            @(negedge clk);
        end
        chk("t6_level0", fifo_level, 0);
        chk("t6_valid_end", m_axis_tvalid, 0);
        m_axis_trdy = 1'b0;

        // 6b: oversize frame is released when the FIFO fills
        wr = 0;
        for (int c = 0; c < 20; c++) begin
            s_axis_tvalid = (wr < 20);
            s_axis_tdata = 32'h700 + wr;
            s_axis_tlast = (wr == 19);
            acc = s_axis_tvalid && s_axis_trdy;
            @(negedge clk);
            if (acc) wr++;
            chk("t6b_valid", m_axis_tvalid, (wr >= 16));
        end
        chk("t6b_level", fifo_level, 16);
        stream(32'h700, 16, 0, 20, 20, 100, 100, 100, cyc);
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
